instruction_fetch: RTL and testbench

Fetch stage of the 5-stage RISC-V pipeline. Holds the 64-bit program counter and a word-organised instruction memory with synchronous read. Each cycle it produces one registered instruction/PC pair that feeds the IF/ID pipeline register directly. Supports hazard stalls and branch/jump redirects from later stages.

---
 rtl/instruction_fetch.sv | 84 ++++++++
 tb/tb_instruction_fetch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// IF stage: 64-bit PC plus word-organised instruction memory, one registered fetch per cycle.
// Latency 1 cycle. No backpressure, stall holds all state. Optional misaligned-redirect trap via IFETCH_MISALIGN_TRAP_EN.
module instruction_fetch #(
  parameter int          IMEM_WORDS = 64,
  parameter logic [63:0] RESET_PC   = 64'h0,
  localparam int         AW         = $clog2(IMEM_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          redirect,
  input  logic [63:0]   redirect_target,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_waddr,
  input  logic [31:0]   imem_wdata,
  output logic [31:0]   instruction,
  output logic [63:0]   PC_Out,
  output logic          fetch_valid
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic          misalign
`endif
);

  localparam logic [31:0] NOP = 32'h00000013;

`ifdef IFETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE, RUN, TRAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  state_t      state;
  logic [63:0] pc;
  logic [31:0] mem [IMEM_WORDS];

  // Memory is never reset; writes land even while reset is low.
  always_ff @(posedge clk) begin
    if (imem_we) mem[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instruction <= NOP;
      PC_Out      <= 64'h0;
      fetch_valid <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      misalign    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: state <= RUN;
        RUN: begin
          if (redirect) begin
            // A redirect beats stall and squashes the sequential fetch.
            instruction <= NOP;
            fetch_valid <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            pc          <= redirect_target;
            if (redirect_target[1:0] != 2'b00) begin
              state    <= TRAP;
              misalign <= 1'b1;
            end
`else
            pc          <= redirect_target & ~64'h3;
`endif
          end else if (!stall) begin
            instruction <= mem[pc[AW+1:2]];
            PC_Out      <= pc;
            fetch_valid <= 1'b1;
            pc          <= pc + 64'd4;
          end
        end
`ifdef IFETCH_MISALIGN_TRAP_EN
        TRAP: state <= TRAP;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed test-plan scenarios plus randomized traffic against a cycle model.
module tb_instruction_fetch;
  localparam int          WORDS = 64;
  localparam logic [63:0] RPC   = 64'h0;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b0, stall = 1'b0, redirect = 1'b0, imem_we = 1'b0;
  logic [63:0] redirect_target = 64'h0;
  logic [5:0]  imem_waddr = 6'd0;
  logic [31:0] imem_wdata = 32'h0;
  logic [31:0] instruction;
  logic [63:0] PC_Out;
  logic        fetch_valid;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state: what the spec says each output should be.
  logic [31:0] m_mem [WORDS];
  logic [63:0] m_pc;
  logic [31:0] m_ins;
  logic [63:0] m_pco;
  logic        m_v, m_run, m_trap;

  instruction_fetch #(.IMEM_WORDS(WORDS), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .instruction(instruction), .PC_Out(PC_Out),
    .fetch_valid(fetch_valid)
`ifdef IFETCH_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit after it.
  task automatic step(input logic rst, input logic stl, input logic rd, input logic [63:0] tgt,
                      input logic we, input logic [5:0] wa, input logic [31:0] wd);
    reset = rst; stall = stl; redirect = rd; redirect_target = tgt;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    @(posedge clk);
    if (!rst) begin
      m_pc = RPC; m_ins = NOP; m_pco = 64'h0; m_v = 1'b0; m_run = 1'b0; m_trap = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1;
    end else if (m_trap) begin
      m_trap = 1'b1;
    end else if (rd) begin
      m_ins = NOP; m_v = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      m_pc = tgt;
      if (tgt % 4 != 0) m_trap = 1'b1;
`else
      m_pc = tgt - (tgt % 4);
`endif
    end else if (!stl) begin
      m_ins = m_mem[int'((m_pc / 4) % WORDS)];
      m_pco = m_pc; m_v = 1'b1; m_pc = m_pc + 64'd4;
    end
    if (we) m_mem[wa] = wd;
    #1;
  endtask

  task automatic run(input logic stl, input logic rd, input logic [63:0] tgt);
    step(1'b1, stl, rd, tgt, 1'b0, 6'd0, 32'h0);
  endtask

  task automatic test_reset;
    logic [31:0] w;
    for (int i = 0; i < WORDS; i++) begin
      w = $urandom;
      if (i < 4) w = 32'h11 * (i + 1);
      if (i == 8) w = 32'hAB;
      step(1'b0, 1'b0, 1'b0, 64'h0, 1'b1, 6'(i), w);
    end
    checks++;
    if ({instruction, PC_Out, fetch_valid} !== {NOP, 64'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values got ins=%h pc=%h v=%b want ins=%h pc=0 v=0", instruction, PC_Out, fetch_valid, NOP);
    end
`ifdef IFETCH_MISALIGN_TRAP_EN
    checks++;
    if (misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got %b want 0", misalign); end
`endif
    run(1'b0, 1'b0, 64'h0);
    checks++;
    if ({instruction, fetch_valid} !== {NOP, 1'b0}) begin
      failures++;
      $display("FAIL idle_bubble got ins=%h v=%b want ins=%h v=0", instruction, fetch_valid, NOP);
    end
  endtask

  task automatic test_sequential;
    for (int k = 1; k <= 4; k++) begin
      run(1'b0, 1'b0, 64'h0);
      checks++;
      if ({instruction, PC_Out, fetch_valid} !== {32'h11 * k, 64'(4 * (k - 1)), 1'b1}) begin
        failures++;
        $display("FAIL seq_edge%0d got ins=%h pc=%h v=%b want ins=%h pc=%h v=1",
                 k, instruction, PC_Out, fetch_valid, 32'h11 * k, 4 * (k - 1));
      end
    end
  endtask

  task automatic test_stall;
    run(1'b0, 1'b1, 64'h0);
    run(1'b0, 1'b0, 64'h0);
    run(1'b0, 1'b0, 64'h0);
    checks++;
    if ({instruction, PC_Out} !== {32'h22, 64'h4}) begin
      failures++; $display("FAIL stall_setup got ins=%h pc=%h want ins=22 pc=4", instruction, PC_Out);
    end
    for (int s = 0; s < 3; s++) begin
      run(1'b1, 1'b0, 64'h0);
      checks++;
      if ({instruction, PC_Out, fetch_valid} !== {32'h22, 64'h4, 1'b1}) begin
        failures++;
        $display("FAIL stall_hold%0d got ins=%h pc=%h v=%b want ins=22 pc=4 v=1", s, instruction, PC_Out, fetch_valid);
      end
    end
    run(1'b0, 1'b0, 64'h0);
    checks++;
    if ({instruction, PC_Out} !== {32'h33, 64'h8}) begin
      failures++; $display("FAIL stall_resume got ins=%h pc=%h want ins=33 pc=8", instruction, PC_Out);
    end
  endtask

  task automatic test_redirect_during_stall;
    run(1'b1, 1'b1, 64'h20);
    checks++;
    if ({instruction, PC_Out, fetch_valid} !== {NOP, 64'h8, 1'b0}) begin
      failures++;
      $display("FAIL redir_bubble got ins=%h pc=%h v=%b want ins=%h pc=8 v=0", instruction, PC_Out, fetch_valid, NOP);
    end
    run(1'b0, 1'b0, 64'h0);
    checks++;
    if ({instruction, PC_Out, fetch_valid} !== {32'hAB, 64'h20, 1'b1}) begin
      failures++;
      $display("FAIL redir_target got ins=%h pc=%h v=%b want ins=ab pc=20 v=1", instruction, PC_Out, fetch_valid);
    end
  endtask

  task automatic test_wrap;
    run(1'b0, 1'b1, 64'hFC);
    run(1'b0, 1'b0, 64'h0);
    checks++;
    if ({instruction, PC_Out} !== {m_mem[63], 64'hFC}) begin
      failures++; $display("FAIL wrap_fc got ins=%h pc=%h want ins=%h pc=fc", instruction, PC_Out, m_mem[63]);
    end
    run(1'b0, 1'b0, 64'h0);
    checks++;
    if ({instruction, PC_Out} !== {32'h11, 64'h100}) begin
      failures++; $display("FAIL wrap_100 got ins=%h pc=%h want ins=11 pc=100", instruction, PC_Out);
    end
  endtask

  task automatic test_misalign;
    run(1'b0, 1'b1, 64'h22);
`ifdef IFETCH_MISALIGN_TRAP_EN
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({misalign, fetch_valid, instruction} !== {1'b1, 1'b0, NOP}) begin
        failures++;
        $display("FAIL trap_hold%0d got mis=%b v=%b ins=%h want mis=1 v=0 ins=%h", c, misalign, fetch_valid, instruction, NOP);
      end
      run(1'($urandom), 1'($urandom), 64'h40);
    end
    step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 6'd0, 32'h0);
    checks++;
    if ({misalign, fetch_valid} !== 2'b00) begin
      failures++; $display("FAIL trap_reset got mis=%b v=%b want mis=0 v=0", misalign, fetch_valid);
    end
    run(1'b0, 1'b0, 64'h0);
`else
    run(1'b0, 1'b0, 64'h0);
    checks++;
    if ({instruction, PC_Out, fetch_valid} !== {m_mem[8], 64'h20, 1'b1}) begin
      failures++;
      $display("FAIL misalign_force got ins=%h pc=%h v=%b want ins=%h pc=20 v=1", instruction, PC_Out, fetch_valid, m_mem[8]);
    end
`endif
  endtask

  task automatic test_random;
    logic [63:0] tgt;
    for (int c = 0; c < 300; c++) begin
      tgt = {$urandom, $urandom};
      if (c % 7 == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF8;
`ifdef IFETCH_MISALIGN_TRAP_EN
      tgt[1:0] = 2'b00;
`endif
      step(1'b1, ($urandom % 4) == 0, ($urandom % 8) == 0, tgt,
           ($urandom % 3) == 0, 6'($urandom), $urandom);
      checks++;
      if ({instruction, PC_Out, fetch_valid} !== {m_ins, m_pco, m_v}) begin
        failures++;
        $display("FAIL random_c%0d got ins=%h pc=%h v=%b want ins=%h pc=%h v=%b",
                 c, instruction, PC_Out, fetch_valid, m_ins, m_pco, m_v);
      end
    end
  endtask

  task automatic test_reset_midrun;
    step(1'b0, 1'b1, 1'b1, 64'h80, 1'b0, 6'd0, 32'h0);
    checks++;
    if ({instruction, PC_Out, fetch_valid} !== {NOP, 64'h0, 1'b0}) begin
      failures++;
      $display("FAIL midrun_reset got ins=%h pc=%h v=%b want ins=%h pc=0 v=0", instruction, PC_Out, fetch_valid, NOP);
    end
    run(1'b0, 1'b1, 64'h80);
    checks++;
    if (fetch_valid !== 1'b0) begin failures++; $display("FAIL midrun_idle got v=%b want 0", fetch_valid); end
    run(1'b0, 1'b0, 64'h0);
    checks++;
    if ({instruction, PC_Out, fetch_valid} !== {m_mem[0], RPC, 1'b1}) begin
      failures++;
      $display("FAIL midrun_first got ins=%h pc=%h v=%b want ins=%h pc=%h v=1", instruction, PC_Out, fetch_valid, m_mem[0], RPC);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_during_stall();
    test_wrap();
    test_misalign();
    test_random();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
